// File: rtl/fsabc_func.sv
// Registered full-adder evaluator: sum, carry and a one-cycle strobe on every sum toggle.
// All three outputs are flops; nothing reaches the outputs combinationally.
module fsabc_func (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic F,
    output logic CO,
    output logic CHG
);

    logic sum_nxt;
    logic carry_nxt;

    always_comb begin
        sum_nxt   = A ^ B ^ C;
        carry_nxt = (A & B) | (A & C) | (B & C);
    end

    // CHG compares the incoming sum against the currently registered F
    always_ff @(posedge clk) begin
        if (rst) begin
            F   <= 1'b0;
            CO  <= 1'b0;
            CHG <= 1'b0;
        end else begin
            F   <= sum_nxt;
            CO  <= carry_nxt;
            CHG <= sum_nxt ^ F;
        end
    end

endmodule

// File: tb/tb_fsabc_func.sv
// Directed plus randomized bench for fsabc_func against a popcount-based reference model.
module tb_fsabc_func;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0;
    logic F, CO, CHG;

    int checks = 0;
    int passed = 0;

    // reference model state: expected outputs after the most recent edge
    logic m_f = 1'b0, m_co = 1'b0, m_chg = 1'b0;

    always #5 clk = ~clk;

    fsabc_func dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .F   (F),
        .CO  (CO),
        .CHG (CHG)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // drive at the falling edge, let one rising edge pass, check 1 time unit later
    task automatic step(input logic [2:0] v, input logic r, input string tag);
        int cnt;
        logic nf;
        @(negedge clk);
        {A, B, C} = v;
        rst = r;
        @(posedge clk);
        #1;
        cnt = int'(v[2]) + int'(v[1]) + int'(v[0]);
        if (r) begin
            m_f = 1'b0; m_co = 1'b0; m_chg = 1'b0;
        end else begin
            nf    = (cnt % 2) == 1;
            m_chg = (nf != m_f);
            m_f   = nf;
            m_co  = (cnt >= 2);
        end
        check({tag, ".F"},   F,   m_f);
        check({tag, ".CO"},  CO,  m_co);
        check({tag, ".CHG"}, CHG, m_chg);
    endtask

    logic [2:0] gray [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};
    logic [7:0] f_tab  = 8'b1001_0110;
    logic [7:0] co_tab = 8'b1110_1000;

    initial begin
        // reset held with 111, then first evaluated edge
        step(3'b111, 1'b1, "rst0");
        step(3'b111, 1'b1, "rst1");
        step(3'b111, 1'b0, "rel");
        check("rel_const.F", F, 1'b1);
        check("rel_const.CHG", CHG, 1'b1);

        // exhaustive truth table, also against literal tables
        for (int i = 0; i < 8; i++) begin
            step(3'(i), 1'b0, "exh");
            check("exh_tab.F",  F,  f_tab[i]);
            check("exh_tab.CO", CO, co_tab[i]);
        end

        // Gray walk from a clean reset, mid-walk reset at 111
        step(3'b000, 1'b1, "gw_rst");
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 10; k++) begin
                step(gray[i], (i == 5 && k == 3), "gray");
                if (k == 0 && i != 5) check("gray_tab.F", F, 1'(i % 2));
            end
        end

        // hold 101 from reset: F never leaves 0, so no strobe
        step(3'b101, 1'b1, "hold_rst");
        for (int k = 0; k < 20; k++) begin
            step(3'b101, 1'b0, "hold");
            check("hold_const.CHG", CHG, 1'b0);
        end

        // multi-bit change 000 -> 110
        step(3'b000, 1'b0, "mb0");
        step(3'b110, 1'b0, "mb1");
        check("mb_const.CO", CO, 1'b1);
        check("mb_const.CHG", CHG, 1'b0);

        // random vectors with occasional reset
        for (int n = 0; n < 300; n++)
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0), "rand");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
